keypoint_stream_out: RTL

KEYPOINT_STREAM_OUT -- requirements
Module: keypoint_stream_out

---
 rtl/keypoint_stream_out_pkg.sv | 37 +++
 rtl/keypoint_stream_out_kp_word_pack.sv | 30 +++
 rtl/keypoint_stream_out.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/keypoint_stream_out_pkg.sv
// Shared constants, state and phase encodings for the keypoint stream dumper.
// Optional trailer checksum is enabled by defining KP_STREAM_CHECKSUM_EN.
package keypoint_stream_out_pkg;

    localparam int unsigned DEPTH  = 2000;
    localparam int unsigned ADDR_W = 11;
    localparam int unsigned KP_W   = 19;

    // Stream word layout
    localparam int unsigned WORD_W  = 16;
    localparam int unsigned SET_BIT = 15;
    localparam int unsigned CNT_W   = 11;
    localparam int unsigned ROW_LSB = 10;
    localparam int unsigned ROW_W   = 9;
    localparam int unsigned COL_W   = 10;

    typedef enum logic [3:0] {
        IDLE,
        HDR,
        RD,
        LAT,
        WA,
        WB,
        NEXT,
        FIN
`ifdef KP_STREAM_CHECKSUM_EN
        , TRL
`endif
    } state_t;

    typedef enum logic [1:0] {
        PH_HDR,
        PH_A,
        PH_B
    } phase_t;

endpackage

// File: rtl/keypoint_stream_out_kp_word_pack.sv
// Combinational formatter: builds a 16-bit header, row (A) or column (B) word.
// For the header phase the set's count is carried in the low bits of kp.
module kp_word_pack
    import keypoint_stream_out_pkg::*;
(
    input  logic              set_id,
    input  logic [KP_W-1:0]   kp,
    input  phase_t            phase,
    output logic [WORD_W-1:0] word
);

    always_comb begin
        word = '0;
        case (phase)
            PH_HDR: begin
                word[SET_BIT]     = set_id;
                word[CNT_W-1:0]   = kp[CNT_W-1:0];
            end
            PH_A: begin
                word[SET_BIT]     = set_id;
                word[ROW_W-1:0]   = kp[ROW_LSB +: ROW_W];
            end
            PH_B: begin
                word[COL_W-1:0]   = kp[COL_W-1:0];
            end
            default: word = '0;
        endcase
    end

endmodule

// File: rtl/keypoint_stream_out.sv
// Dumps two keypoint memories as a ready/valid 16-bit word stream.
// Define KP_STREAM_CHECKSUM_EN to append an XOR trailer word to each set.
module keypoint_stream_out #(
    parameter int unsigned DEPTH  = keypoint_stream_out_pkg::DEPTH,
    parameter int unsigned ADDR_W = keypoint_stream_out_pkg::ADDR_W,
    parameter int unsigned KP_W   = keypoint_stream_out_pkg::KP_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] kp1_count,
    input  logic [ADDR_W-1:0] kp2_count,
    output logic [ADDR_W-1:0] kp1_addr,
    input  logic [KP_W-1:0]   kp1_dout,
    output logic [ADDR_W-1:0] kp2_addr,
    input  logic [KP_W-1:0]   kp2_dout,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [15:0]       out_data,
    output logic              busy,
    output logic              done
);

    import keypoint_stream_out_pkg::*;

    localparam logic [ADDR_W-1:0] DEPTH_CNT = ADDR_W'(DEPTH);

    state_t            state, state_nx;
    phase_t            phase;
    logic              set_sel;
    logic [ADDR_W-1:0] cnt1, cnt2, idx, cur_cnt;
    logic [KP_W-1:0]   kp_q, pack_kp;
    logic [15:0]       pack_word;
    logic              accept, last_entry;

    assign cur_cnt    = set_sel ? cnt2 : cnt1;
    assign accept     = out_valid & out_ready;
    assign last_entry = (idx == cur_cnt - 1'b1);
    assign pack_kp    = (phase == PH_HDR) ? KP_W'(cur_cnt) : kp_q;

    kp_word_pack u_pack (
        .set_id (set_sel),
        .kp     (pack_kp),
        .phase  (phase),
        .word   (pack_word)
    );

`ifdef KP_STREAM_CHECKSUM_EN
    logic [15:0] csum;
    logic        trl_sel;

    // Header restarts the running XOR; every later accepted word folds in.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            csum <= '0;
        end else if (accept) begin
            csum <= (state == HDR) ? out_data : (csum ^ out_data);
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        out_valid = 1'b0;
        phase     = PH_HDR;
        busy      = (state != IDLE);
        done      = 1'b0;
`ifdef KP_STREAM_CHECKSUM_EN
        trl_sel   = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (start) state_nx = HDR;
            end
            HDR: begin
                out_valid = 1'b1;
                phase     = PH_HDR;
                if (accept) begin
`ifdef KP_STREAM_CHECKSUM_EN
                    state_nx = (cur_cnt == '0) ? TRL : RD;
`else
                    state_nx = (cur_cnt == '0) ? NEXT : RD;
`endif
                end
            end
            RD:  state_nx = LAT;
            LAT: state_nx = WA;
            WA: begin
                out_valid = 1'b1;
                phase     = PH_A;
                if (accept) state_nx = WB;
            end
            WB: begin
                out_valid = 1'b1;
                phase     = PH_B;
                if (accept) begin
`ifdef KP_STREAM_CHECKSUM_EN
                    state_nx = last_entry ? TRL : RD;
`else
                    state_nx = last_entry ? NEXT : RD;
`endif
                end
            end
`ifdef KP_STREAM_CHECKSUM_EN
            TRL: begin
                out_valid = 1'b1;
                trl_sel   = 1'b1;
                if (accept) state_nx = NEXT;
            end
`endif
            NEXT: state_nx = set_sel ? FIN : HDR;
            FIN: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        out_data = '0;
        if (out_valid) begin
`ifdef KP_STREAM_CHECKSUM_EN
            out_data = trl_sel ? csum : pack_word;
`else
            out_data = pack_word;
`endif
        end
    end

    // Clamped counts are captured only when a dump actually begins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt1    <= '0;
            cnt2    <= '0;
            idx     <= '0;
            set_sel <= 1'b0;
            kp_q    <= '0;
        end else begin
            if (state == IDLE && start) begin
                cnt1    <= (kp1_count > DEPTH_CNT) ? DEPTH_CNT : kp1_count;
                cnt2    <= (kp2_count > DEPTH_CNT) ? DEPTH_CNT : kp2_count;
                idx     <= '0;
                set_sel <= 1'b0;
            end
            if (state == LAT) begin
                kp_q <= set_sel ? kp2_dout : kp1_dout;
            end
            if (state == WB && accept && !last_entry) begin
                idx <= idx + 1'b1;
            end
            if (state == NEXT) begin
                idx     <= '0;
                set_sel <= 1'b1;
            end
        end
    end

    assign kp1_addr = (state == RD && !set_sel) ? idx : '0;
    assign kp2_addr = (state == RD &&  set_sel) ? idx : '0;

endmodule
